// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Package  : median_pkg
// Desc     : Shared state type and default sizing for the median filter front end.
// Revision : 1.0
// ============================================================================
package median_pkg;

    localparam int DEF_DIM_WIDTH   = 13;
    localparam int DEF_KERNEL_SIZE = 5;
    localparam int LB_SEL_W        = $clog2(DEF_KERNEL_SIZE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        ACTIVE   = 3'd2,
        FLUSH    = 3'd3,
        DONE     = 3'd4
    } ctrl_state_t;

endpackage : median_pkg
`default_nettype wire

// File: rtl/median_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : median_pos_counter
// Desc     : Column/row position tracker with rotating line-buffer select.
// Revision : 1.0
// ============================================================================
module median_pos_counter
    import median_pkg::*;
#(
    parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [DIM_WIDTH-1:0]           width_i,
    input  logic [DIM_WIDTH-1:0]           height_i,
    input  logic                           sof_i,
    input  logic                           inc_i,
    input  logic                           adv_i,
    output logic [DIM_WIDTH-2:0]           col_o,
    output logic [$clog2(KERNEL_SIZE)-1:0] sel_o,
    output logic                           origin_o,
    output logic                           last_col_o,
    output logic                           last_row_o
);

    localparam int SEL_W = $clog2(KERNEL_SIZE);

    logic [DIM_WIDTH-2:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic [SEL_W-1:0]     sel_q, sel_d;

    // The SOF beat itself occupies column 0, so a restart leaves the
    // counter pointing at the beat that follows it.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sel_d = sel_q;
        if (sof_i) begin
            col_d = (DIM_WIDTH-1)'(1);
            row_d = '0;
            sel_d = '0;
        end else if (adv_i) begin
            col_d = '0;
            row_d = row_q + DIM_WIDTH'(1);
            sel_d = (sel_q == SEL_W'(KERNEL_SIZE - 1)) ? '0 : sel_q + SEL_W'(1);
        end else if (inc_i) begin
            col_d = col_q + (DIM_WIDTH-1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            sel_q <= sel_d;
        end
    end

    assign col_o      = col_q;
    assign sel_o      = sel_q;
    assign origin_o   = (col_q == '0) && (row_q == '0);
    assign last_col_o = ({1'b0, col_q} == (width_i - DIM_WIDTH'(1)));
    assign last_row_o = (row_q == (height_i - DIM_WIDTH'(1)));

endmodule : median_pos_counter
`default_nettype wire

// File: rtl/median_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : median_frame_ctrl
// Desc     : AXIS input sequencer steering pixels into rotating line buffers.
// Revision : 1.0
// ============================================================================
module median_frame_ctrl
    import median_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int DIM_WIDTH   = DEF_DIM_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_aresetn,
    input  logic                           i_enable,
    input  logic [DIM_WIDTH-1:0]           IMG_WIDTH,
    input  logic [DIM_WIDTH-1:0]           IMG_HEIGHT,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tuser,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [DATA_WIDTH-1:0]          o_pixel,
    output logic                           o_image_data_valid,
    output logic                           o_start_of_frame,
    output logic [$clog2(KERNEL_SIZE)-1:0] o_lb_wr_sel,
    output logic [DIM_WIDTH-2:0]           o_lb_wr_addr,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic                           o_err_early_eol,
    output logic                           o_err_late_eol,
    output logic                           o_err_sof
);

    localparam int SEL_W = $clog2(KERNEL_SIZE);

    ctrl_state_t           state_q, state_d;
    logic [DIM_WIDTH-1:0]  width_q, height_q;
    logic                  tready_q;
    logic [DATA_WIDTH-1:0] pixel_q;
    logic                  valid_q, sof_q, busy_q, done_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DIM_WIDTH-2:0]  addr_q;
    logic                  err_early_q, err_late_q, err_sof_q;

    logic                  beat, dims_ok;
    logic                  emit, restart, cnt_inc, cnt_adv;
    logic                  done_d, err_early_d, err_late_d, err_sof_d;
    logic [DIM_WIDTH-2:0]  col;
    logic [SEL_W-1:0]      sel;
    logic                  at_origin, last_col, last_row;

    assign beat    = s_axis_tvalid & tready_q;
    assign dims_ok = (IMG_WIDTH >= DIM_WIDTH'(KERNEL_SIZE)) &&
                     (IMG_HEIGHT >= DIM_WIDTH'(KERNEL_SIZE));

    median_pos_counter #(
        .DIM_WIDTH   (DIM_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_pos (
        .clk_i      (i_clk),
        .rst_ni     (i_aresetn),
        .width_i    (width_q),
        .height_i   (height_q),
        .sof_i      (restart),
        .inc_i      (cnt_inc),
        .adv_i      (cnt_adv),
        .col_o      (col),
        .sel_o      (sel),
        .origin_o   (at_origin),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    always_comb begin
        state_d     = state_q;
        emit        = 1'b0;
        restart     = 1'b0;
        cnt_inc     = 1'b0;
        cnt_adv     = 1'b0;
        done_d      = 1'b0;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        err_sof_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable && dims_ok) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (beat && s_axis_tuser) begin
                    emit    = 1'b1;
                    restart = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat) begin
                    emit = 1'b1;
                    if (s_axis_tuser) begin
                        restart   = 1'b1;
                        err_sof_d = !at_origin;
                    end else if (!last_col) begin
                        if (s_axis_tlast) begin
                            err_early_d = 1'b1;
                            cnt_adv     = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        cnt_adv = 1'b1;
                        if (last_row) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        // Row stays put until the overlong line's tlast shows up.
                        err_late_d = 1'b1;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (beat) begin
                    if (s_axis_tuser) begin
                        emit      = 1'b1;
                        restart   = 1'b1;
                        err_sof_d = 1'b1;
                        state_d   = ACTIVE;
                    end else if (s_axis_tlast) begin
                        cnt_adv = 1'b1;
                        if (last_row) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = i_enable ? WAIT_SOF : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            tready_q    <= 1'b0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            err_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tready_q    <= (state_d == WAIT_SOF) || (state_d == ACTIVE) || (state_d == FLUSH);
            busy_q      <= (state_d == ACTIVE) || (state_d == FLUSH);
            valid_q     <= emit;
            sof_q       <= restart;
            done_q      <= done_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            err_sof_q   <= err_sof_d;
            if (restart) begin
                width_q  <= IMG_WIDTH;
                height_q <= IMG_HEIGHT;
            end
            if (emit) begin
                pixel_q <= s_axis_tdata;
                addr_q  <= restart ? '0 : col;
                sel_q   <= restart ? '0 : sel;
            end
        end
    end

    assign s_axis_tready      = tready_q;
    assign o_pixel            = pixel_q;
    assign o_image_data_valid = valid_q;
    assign o_start_of_frame   = sof_q;
    assign o_lb_wr_sel        = sel_q;
    assign o_lb_wr_addr       = addr_q;
    assign o_busy             = busy_q;
    assign o_frame_done       = done_q;
    assign o_err_early_eol    = err_early_q;
    assign o_err_late_eol     = err_late_q;
    assign o_err_sof          = err_sof_q;

endmodule : median_frame_ctrl
`default_nettype wire

// File: tb/tb_median_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_median_frame_ctrl
// Desc     : Self-checking bench; expected stream derived from per-line lengths.
// Revision : 1.0
// ============================================================================
module tb_median_frame_ctrl;

    localparam int DW   = 8;
    localparam int K    = 5;
    localparam int DIMW = 13;

    logic            i_clk = 1'b0;
    logic            i_aresetn;
    logic            i_enable;
    logic [DIMW-1:0] IMG_WIDTH, IMG_HEIGHT;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tuser, s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   o_pixel;
    logic            o_image_data_valid, o_start_of_frame;
    logic [2:0]      o_lb_wr_sel;
    logic [DIMW-2:0] o_lb_wr_addr;
    logic            o_busy, o_frame_done;
    logic            o_err_early_eol, o_err_late_eol, o_err_sof;

    median_frame_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .DIM_WIDTH(DIMW)) dut (
        .i_clk              (i_clk),
        .i_aresetn          (i_aresetn),
        .i_enable           (i_enable),
        .IMG_WIDTH          (IMG_WIDTH),
        .IMG_HEIGHT         (IMG_HEIGHT),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .o_pixel            (o_pixel),
        .o_image_data_valid (o_image_data_valid),
        .o_start_of_frame   (o_start_of_frame),
        .o_lb_wr_sel        (o_lb_wr_sel),
        .o_lb_wr_addr       (o_lb_wr_addr),
        .o_busy             (o_busy),
        .o_frame_done       (o_frame_done),
        .o_err_early_eol    (o_err_early_eol),
        .o_err_late_eol     (o_err_late_eol),
        .o_err_sof          (o_err_sof)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] d;
        bit u, l;
        int w, h;
        bit ev, esof, ee, el, es, edone, ebusy;
        int addr, sel;
    } beat_t;

    beat_t bq[$];
    int    len[16];
    int    n_pass = 0;
    int    n_tot  = 0;
    int    n_valid;
    int    phase;      // 0: idle, 1: frame just finished, 2: accepting beats
    bit    exp_rdy, exp_busy, gaps;
    int    cur_w, cur_h;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycle(bit v, beat_t b);
        bit acc;
        chk("tready", {31'd0, s_axis_tready}, {31'd0, exp_rdy});
        chk("busy", {31'd0, o_busy}, {31'd0, exp_busy});
        acc           = v && (phase == 2);
        s_axis_tvalid = v;
        s_axis_tdata  = b.d;
        s_axis_tuser  = b.u;
        s_axis_tlast  = b.l;
        IMG_WIDTH     = DIMW'(b.w);
        IMG_HEIGHT    = DIMW'(b.h);
        @(posedge i_clk);
        #1;
        chk("valid", {31'd0, o_image_data_valid}, {31'd0, acc && b.ev});
        chk("sof", {31'd0, o_start_of_frame}, {31'd0, acc && b.esof});
        chk("err_early", {31'd0, o_err_early_eol}, {31'd0, acc && b.ee});
        chk("err_late", {31'd0, o_err_late_eol}, {31'd0, acc && b.el});
        chk("err_sof", {31'd0, o_err_sof}, {31'd0, acc && b.es});
        chk("frame_done", {31'd0, o_frame_done}, {31'd0, acc && b.edone});
        if (acc && b.ev) begin
            chk("pixel", {24'd0, o_pixel}, {24'd0, b.d});
            chk("addr", {20'd0, o_lb_wr_addr}, b.addr);
            chk("sel", {29'd0, o_lb_wr_sel}, b.sel);
            n_valid++;
        end
        if (phase == 0)
            phase = (i_enable && IMG_WIDTH >= K && IMG_HEIGHT >= K) ? 2 : 0;
        else if (phase == 1)
            phase = i_enable ? 2 : 0;
        else if (acc && b.edone)
            phase = 1;
        if (acc) exp_busy = b.ebusy;
        else if (phase != 2) exp_busy = 1'b0;
        exp_rdy = (phase == 2);
    endtask

    task automatic idle(int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b   = '{default: 0};
            b.d = 8'($urandom);
            b.w = (phase == 2) ? $urandom_range(1, 40) : cur_w;
            b.h = (phase == 2) ? $urandom_range(1, 40) : cur_h;
            cycle(1'b0, b);
        end
    endtask

    task automatic warmup();
        for (int i = 0; i < 4 && phase != 2; i++) idle(1);
    endtask

    task automatic play();
        beat_t b;
        warmup();
        while (bq.size() > 0) begin
            b = bq.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            cycle(1'b1, b);
            if (b.edone) idle(1);
        end
    endtask

    task automatic set_clean(int W, int H);
        for (int r = 0; r < H; r++) len[r] = W;
    endtask

    // Expected outputs follow from the line lengths: short lines end early,
    // long lines emit W pixels and swallow the rest, the last full row ends the frame.
    task automatic gen_frame(int W, int H, int njunk, bit restart, int cut_r, int cut_c);
        beat_t b;
        int    L;
        for (int j = 0; j < njunk; j++) begin
            b   = '{default: 0};
            b.d = 8'($urandom);
            b.l = 1'($urandom_range(0, 1));
            b.w = $urandom_range(1, 40);
            b.h = $urandom_range(1, 40);
            bq.push_back(b);
        end
        for (int r = 0; r < H; r++) begin
            L = len[r];
            for (int c = 0; c < L; c++) begin
                if (r == cut_r && c == cut_c) return;
                b   = '{default: 0};
                b.d = 8'($urandom);
                b.u = (r == 0 && c == 0);
                b.l = (c == L - 1);
                b.w = b.u ? W : $urandom_range(1, 40);
                b.h = b.u ? H : $urandom_range(1, 40);
                if (c < W) begin
                    b.ev    = 1'b1;
                    b.addr  = c;
                    b.sel   = r % K;
                    b.esof  = b.u;
                    b.es    = b.u && restart;
                    b.ee    = (L < W) && (c == L - 1);
                    b.el    = (L > W) && (c == W - 1);
                    b.edone = (L == W) && (c == W - 1) && (r == H - 1);
                end else begin
                    b.edone = (c == L - 1) && (r == H - 1);
                end
                b.ebusy = !b.edone;
                bq.push_back(b);
            end
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_tready"}, {31'd0, s_axis_tready}, 0);
        chk({tag, "_valid"}, {31'd0, o_image_data_valid}, 0);
        chk({tag, "_sof"}, {31'd0, o_start_of_frame}, 0);
        chk({tag, "_pixel"}, {24'd0, o_pixel}, 0);
        chk({tag, "_sel"}, {29'd0, o_lb_wr_sel}, 0);
        chk({tag, "_addr"}, {20'd0, o_lb_wr_addr}, 0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 0);
        chk({tag, "_done"}, {31'd0, o_frame_done}, 0);
        chk({tag, "_errs"}, {29'd0, o_err_early_eol, o_err_late_eol, o_err_sof}, 0);
    endtask

    initial begin
        int W, H, p;
        i_aresetn     = 1'b0;
        i_enable      = 1'b1;
        cur_w         = 8;
        cur_h         = 6;
        IMG_WIDTH     = DIMW'(cur_w);
        IMG_HEIGHT    = DIMW'(cur_h);
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        gaps          = 1'b0;
        phase         = 0;
        exp_rdy       = 1'b0;
        exp_busy      = 1'b0;
        repeat (2) @(negedge i_clk);
        check_all_zero("reset");
        i_aresetn = 1'b1;
        #1;

        // Clean 8x6 frame, tvalid held high.
        n_valid = 0;
        set_clean(8, 6);
        gen_frame(8, 6, 0, 1'b0, -1, -1);
        play();
        chk("frame1_pixel_count", n_valid, 48);

        // Two junk beats ahead of SOF.
        set_clean(8, 6);
        gen_frame(8, 6, 2, 1'b0, -1, -1);
        play();

        // Early EOL on column 5 of row 2.
        set_clean(8, 6);
        len[2] = 6;
        gen_frame(8, 6, 0, 1'b0, -1, -1);
        play();

        // Late EOL: row 1 carries three extra beats.
        set_clean(8, 6);
        len[1] = 11;
        gen_frame(8, 6, 0, 1'b0, -1, -1);
        play();

        // Restart at (3,2) with new dimensions.
        set_clean(8, 6);
        gen_frame(8, 6, 0, 1'b0, 2, 3);
        set_clean(10, 5);
        gen_frame(10, 5, 0, 1'b1, -1, -1);
        play();

        // Randomized frames with gaps and malformed lines.
        gaps = 1'b1;
        for (int f = 0; f < 6; f++) begin
            W = $urandom_range(5, 12);
            H = $urandom_range(5, 8);
            for (int r = 0; r < H; r++) begin
                p = $urandom_range(0, 9);
                if (p == 0 && r != H - 1) len[r] = $urandom_range(1, W - 1);
                else if (p == 1)          len[r] = W + $urandom_range(1, 3);
                else                      len[r] = W;
            end
            gen_frame(W, H, $urandom_range(0, 2), 1'b0, -1, -1);
            play();
        end
        gaps = 1'b0;

        // Enable dropped mid-frame: frame completes, then the block parks in IDLE.
        set_clean(6, 5);
        gen_frame(6, 5, 0, 1'b0, -1, -1);
        warmup();
        i_enable = 1'b0;
        play();
        idle(3);
        i_enable = 1'b1;

        // Reset in the middle of row 3.
        set_clean(8, 6);
        gen_frame(8, 6, 0, 1'b0, 3, 4);
        play();
        #3;
        i_aresetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        bq.delete();
        phase    = 0;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        @(negedge i_clk);
        cur_w     = 4;
        IMG_WIDTH = DIMW'(cur_w);
        i_aresetn = 1'b1;
        #1;

        // Undersized width keeps the block in IDLE.
        idle(5);
        cur_w = 8;
        set_clean(8, 6);
        gen_frame(8, 6, 1, 1'b0, -1, -1);
        play();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_median_frame_ctrl
`default_nettype wire

// File: doc/median_frame_ctrl.md
# median_frame_ctrl

Input-side sequencer for the 5x5 median filter. It accepts the incoming AXI4-Stream video and latches frame dimensions at start of frame. It tracks pixel and line position, steers each accepted pixel into one of KERNEL_SIZE rotating line buffers, and produces the `o_image_data_valid` / `o_start_of_frame` strobes consumed by the output framing FSM. It also detects and recovers from malformed lines.

## Interface
- `DATA_WIDTH`, 8: pixel width.
- `KERNEL_SIZE`, 5: line buffers in rotation; minimum legal image dimension.
- `DIM_WIDTH`, 13: width of dimension inputs.
- `i_clk`  in  1  single clock, all logic rising-edge.
- `i_aresetn`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  frame-level enable; sampled only in IDLE and DONE.
- `IMG_WIDTH`  in  DIM_WIDTH  pixels per line; latched at SOF.
- `IMG_HEIGHT`  in  DIM_WIDTH  lines per frame; latched at SOF.
- `s_axis_tdata`  in  DATA_WIDTH  input pixel.
- `s_axis_tvalid`, `s_axis_tuser`, `s_axis_tlast`  in  1 each  AXIS beat valid, start of frame, end of line.
- `s_axis_tready`  out  1  accept beat.
- `o_pixel`  out  DATA_WIDTH  registered copy of the accepted pixel.
- `o_image_data_valid`  out  1  `o_pixel` / `o_lb_*` valid this cycle.
- `o_start_of_frame`  out  1  accompanies pixel (0,0) only.
- `o_lb_wr_sel`  out  $clog2(KERNEL_SIZE)  target line buffer = row mod KERNEL_SIZE.
- `o_lb_wr_addr`  out  DIM_WIDTH-1  column index.
- `o_busy`  out  1  high in ACTIVE and FLUSH.
- `o_frame_done`  out  1  one-cycle pulse after the last pixel.
- `o_err_early_eol`, `o_err_late_eol`, `o_err_sof`  out  1 each  one-cycle error pulses.

## Operation
- Accepted beat = `s_axis_tvalid & s_axis_tready`. `s_axis_tready` is Moore: 1 in WAIT_SOF, ACTIVE and FLUSH; 0 in IDLE and DONE.
- IDLE: go to WAIT_SOF when `i_enable` is 1 and `IMG_WIDTH` ≥ KERNEL_SIZE and `IMG_HEIGHT` ≥ KERNEL_SIZE; otherwise stay in IDLE.
- WAIT_SOF:
  - Beats with tuser=0 are discarded (no valid out).
  - A beat with tuser=1 latches W/H, sets col=row=0, emits pixel (0,0) with `o_start_of_frame`=1, and goes to ACTIVE.
- ACTIVE, per accepted beat at (col,row), emit a pixel with addr=col and sel=row mod K:
  - col < W-1, tlast=0: col++.
  - col < W-1, tlast=1 (early EOL): pulse `o_err_early_eol`, col=0, row advances. The short line is not padded.
  - col = W-1, tlast=1: col=0, row advances. If row = H-1, go to DONE.
  - col = W-1, tlast=0 (late EOL): pulse `o_err_late_eol` and go to FLUSH. The row is not advanced yet.
  - tuser=1 at any position other than (0,0): pulse `o_err_sof` and restart the frame. This beat becomes pixel (0,0) with `o_start_of_frame`=1, and W/H are re-latched.
- FLUSH:
  - Discard beats with no valid out.
  - On tlast: col=0 and row advances. Go to DONE if that row was H-1, else ACTIVE.
  - On tuser: behave as a restart with `o_err_sof`.
- DONE: one cycle, with `o_frame_done`=1. Go to WAIT_SOF if `i_enable`, else IDLE.
- Row advance wraps `o_lb_wr_sel` from K-1 to 0.
- Changes to `IMG_WIDTH`/`IMG_HEIGHT` mid-frame are ignored.
- Deasserting `i_enable` mid-frame has no effect until DONE.

## Timing
- Reset: state IDLE. Every output, including `s_axis_tready` and all counters, is 0.
- Reset mid-frame aborts immediately. No `o_frame_done` is produced. After release the block waits in IDLE/WAIT_SOF for a fresh tuser.
- Latency: an accepted beat at edge N appears on `o_pixel`/`o_image_data_valid` after edge N, i.e. one cycle.
- Throughput: one pixel per clock when `s_axis_tvalid` is held high.
- Error pulses and `o_frame_done` are registered and aligned with the cycle after the causing beat.
- Backpressure is not generated inside a frame; the downstream consumer must accept one pixel per cycle.
- Comparisons: col against W-1 and row against H-1, both zero-extended. No arithmetic overflow, since W,H ≥ K ≥ 2.

## Structure
- Package `median_pkg` holds:
  - `ctrl_state_t` (IDLE, WAIT_SOF, ACTIVE, FLUSH, DONE);
  - the DIM_WIDTH and KERNEL_SIZE defaults;
  - the `LB_SEL_W = $clog2(KERNEL_SIZE)` localparam.
- Sub-module `median_pos_counter` provides the col/row counters: increment, line-advance, row-mod-K select, last-col and last-row flags, and synchronous restart.

## Test plan
- W=8, H=6, clean frame, tvalid held high:
  - 48 valid pixels;
  - `o_start_of_frame` only on the first;
  - sel sequence 0,1,2,3,4,0 per line;
  - `o_frame_done` one cycle after pixel 47;
  - tready low for exactly one cycle.
- Two junk beats with tuser=0 before SOF: both discarded, first output is the SOF beat.
- W=8, tlast on col 5 of row 2: `o_err_early_eol` pulses, next beat has addr 0 and sel 3, and the frame still finishes at row 5.
- W=8, no tlast at col 7 of row 1, three extra beats, tlast on the third: `o_err_late_eol` pulses, those beats produce no valid out, and the next pixel has addr 0 and sel 2.
- tuser=1 at (3,2): `o_err_sof` pulses, the beat is emitted as (0,0) with `o_start_of_frame`, and W/H are re-latched with new values.
- Other scenarios:
  - Reset asserted mid-row 3: all outputs 0 asynchronously, and a new frame is processed cleanly afterwards.
  - IMG_WIDTH=4 with `i_enable`=1: the block stays in IDLE with tready=0.
